// File: rtl/shiftreg_pkg.sv
// Shared definitions for the framed SPI shift register: bit-order encodings,
// frame state type and a constant-foldable ceil(log2) helper.
package shiftreg_pkg;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frameState_t;

  // Smallest r with 2**r >= value; used to size the bit counter.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/framed_bit_counter.sv
// WIDTH-modulo shift counter. Clear wins over enable; the wrap pulse is
// registered so it is seen in the cycle after the final shift of a word.
module framed_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Count shifts, wrap to zero after the last bit and flag the wrap for one cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (enable) begin
        if (count == LAST) begin
          count <= '0;
          wrap  <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/framed_shift_register.sv
// SPI-side shift register with split sample/shift edges, run-time bit order,
// chip-select framing and an end-of-word strobe.
//
//  state  | meaning
//  IDLE   | chip-select released; edges ignored, bit counter held at zero
//  ACTIVE | chip-select asserted; edges capture/shift, counter tracks the word
//
// Edge gating follows frameActive directly so the very first edge of a frame
// (while the state register still reads IDLE) is honoured.
module framed_shift_register
  import shiftreg_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter bit SAMPLE_BYPASS = 1'b0,
  localparam int CNT_W        = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             frameActive,
  input  logic             sampleEdge,
  input  logic             shiftEdge,
  input  logic             lsbFirst,
  input  logic             parallelLoad,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic [CNT_W-1:0] bitCount,
  output logic             wordDone
);

  frameState_t      state;
  frameState_t      nextState;
  logic [WIDTH-1:0] shreg;
  logic             sampledBit;
  logic             inBit;
  logic             sampleEn;
  logic             shiftEn;
  logic             cntClear;

  // Frame state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Frame transitions and edge qualification; a load always clears the counter.
  always_comb begin
    nextState = state;
    sampleEn  = 1'b0;
    shiftEn   = 1'b0;
    cntClear  = 1'b1;
    case (state)
      IDLE: begin
        if (frameActive) begin
          nextState = ACTIVE;
          sampleEn  = sampleEdge;
          shiftEn   = shiftEdge & ~parallelLoad;
          cntClear  = parallelLoad;
        end
      end
      ACTIVE: begin
        if (!frameActive) begin
          nextState = IDLE;
        end else begin
          sampleEn  = sampleEdge;
          shiftEn   = shiftEdge & ~parallelLoad;
          cntClear  = parallelLoad;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign inBit = SAMPLE_BYPASS ? serialDataIn : sampledBit;

  // Shift datapath: load beats shift; direction chosen by lsbFirst each cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shreg <= '0;
    end else if (parallelLoad) begin
      shreg <= parallelDataIn;
    end else if (shiftEn) begin
      if (lsbFirst == LSB_FIRST) begin
        shreg <= {inBit, shreg[WIDTH-1:1]};
      end else begin
        shreg <= {shreg[WIDTH-2:0], inBit};
      end
    end
  end

  // Capture the serial input on the sample edge; a same-cycle shift still sees the old bit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sampledBit <= 1'b0;
    end else if (sampleEn) begin
      sampledBit <= serialDataIn;
    end
  end

  framed_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) uBitCounter (
    .clk    (clk),
    .resetN (resetN),
    .clear  (cntClear),
    .enable (shiftEn),
    .count  (bitCount),
    .wrap   (wordDone)
  );

  assign parallelDataOut = shreg;
  assign serialDataOut   = (lsbFirst == LSB_FIRST) ? shreg[0] : shreg[WIDTH-1];

endmodule

// File: tb/tb_framed_shift_register.sv
// Bench for framed_shift_register: two instances (sampled and bypass input)
// driven in parallel and compared against an arithmetic word-level model.
module tb_framed_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetN;
  logic         frameActive;
  logic         sampleEdge;
  logic         shiftEdge;
  logic         lsbFirst;
  logic         parallelLoad;
  logic [W-1:0] parallelDataIn;
  logic         serialDataIn;

  logic [W-1:0] pdoA, pdoB;
  logic         sdoA, sdoB;
  logic [2:0]   cntA, cntB;
  logic         doneA, doneB;

  int total = 0;
  int bad   = 0;

  // Reference model: words as integers, index 0 = sampled input, 1 = bypass.
  int mShreg[2];
  int mSampled;
  int mCount;
  int mDone;

  always #10 clk = ~clk;

  framed_shift_register #(.WIDTH(W), .SAMPLE_BYPASS(1'b0)) dutA (
    .clk(clk), .resetN(resetN), .frameActive(frameActive), .sampleEdge(sampleEdge),
    .shiftEdge(shiftEdge), .lsbFirst(lsbFirst), .parallelLoad(parallelLoad),
    .parallelDataIn(parallelDataIn), .serialDataIn(serialDataIn),
    .parallelDataOut(pdoA), .serialDataOut(sdoA), .bitCount(cntA), .wordDone(doneA));

  framed_shift_register #(.WIDTH(W), .SAMPLE_BYPASS(1'b1)) dutB (
    .clk(clk), .resetN(resetN), .frameActive(frameActive), .sampleEdge(sampleEdge),
    .shiftEdge(shiftEdge), .lsbFirst(lsbFirst), .parallelLoad(parallelLoad),
    .parallelDataIn(parallelDataIn), .serialDataIn(serialDataIn),
    .parallelDataOut(pdoB), .serialDataOut(sdoB), .bitCount(cntB), .wordDone(doneB));

  task automatic modelReset();
    mShreg[0] = 0;
    mShreg[1] = 0;
    mSampled  = 0;
    mCount    = 0;
    mDone     = 0;
  endtask

  task automatic modelStep();
    int doneNext;
    int inBit;
    doneNext = 0;
    if (parallelLoad) begin
      mShreg[0] = int'(parallelDataIn);
      mShreg[1] = int'(parallelDataIn);
      mCount    = 0;
    end else if (frameActive && shiftEdge) begin
      for (int k = 0; k < 2; k++) begin
        inBit = (k == 0) ? mSampled : int'(serialDataIn);
        if (lsbFirst) mShreg[k] = mShreg[k] / 2 + inBit * (1 << (W - 1));
        else          mShreg[k] = (mShreg[k] * 2 + inBit) % (1 << W);
      end
      mCount = (mCount + 1) % W;
      if (mCount == 0) doneNext = 1;
    end else if (!frameActive) begin
      mCount = 0;
    end
    if (frameActive && sampleEdge) mSampled = int'(serialDataIn);
    mDone = doneNext;
  endtask

  // One clock: model follows the edge, outputs become observable 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!resetN) modelReset();
    else         modelStep();
    #1;
  endtask

  task automatic quietInputs();
    sampleEdge   = 1'b0;
    shiftEdge    = 1'b0;
    parallelLoad = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; frameActive = 1'b1; sampleEdge = 1'b1; shiftEdge = 1'b1;
    lsbFirst = 1'b0; parallelLoad = 1'b0; parallelDataIn = 8'hFF; serialDataIn = 1'b1;
    modelReset();
    #5;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({pdoA, sdoA, cntA, doneA, pdoB, sdoB, cntB, doneB} !== '0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got pdoA=%h sdoA=%b cntA=%0d doneA=%b pdoB=%h, expected all zero", i, pdoA, sdoA, cntA, doneA, pdoB);
      end
      tick();
    end
    resetN = 1'b1; parallelLoad = 1'b1; shiftEdge = 1'b0; sampleEdge = 1'b0;
    tick();
    parallelLoad = 1'b0; shiftEdge = 1'b1;
    repeat (3) tick();
    resetN = 1'b0;
    #2;
    total++;
    if ({pdoA, sdoA, cntA, doneA, pdoB, cntB, doneB} !== '0) begin
      bad++;
      $display("FAIL reset_async: got pdoA=%h sdoA=%b cntA=%0d doneA=%b, expected all zero", pdoA, sdoA, cntA, doneA);
    end
    tick();
    resetN = 1'b1;
    quietInputs();
    tick();
    total++;
    if (cntA !== 3'd0 || doneA !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got cnt=%0d done=%b, expected cnt=0 done=0", cntA, doneA);
    end
    shiftEdge = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++;
      if (doneA !== 1'b0 || cntA !== 3'(i)) begin
        bad++;
        $display("FAIL reset_restart[%0d]: got cnt=%0d done=%b, expected cnt=%0d done=0", i, cntA, doneA, i);
      end
    end
    quietInputs();
  endtask

  task automatic test_msb_first();
    logic [7:0] inBits;
    logic [7:0] outBits;
    inBits  = 8'b1011_0010;
    outBits = 8'hC4;
    frameActive = 1'b0; lsbFirst = 1'b0;
    tick();
    frameActive = 1'b1; parallelLoad = 1'b1; parallelDataIn = 8'hC4;
    tick();
    parallelLoad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (sdoA !== outBits[7-i]) begin
        bad++;
        $display("FAIL msb_sdo[%0d]: got %b, expected %b", i, sdoA, outBits[7-i]);
      end
      serialDataIn = inBits[7-i]; sampleEdge = 1'b1;
      tick();
      sampleEdge = 1'b0; shiftEdge = 1'b1;
      tick();
      shiftEdge = 1'b0;
      total++;
      if (cntA !== 3'((i + 1) % 8) || doneA !== (i == 7)) begin
        bad++;
        $display("FAIL msb_count[%0d]: got cnt=%0d done=%b, expected cnt=%0d done=%b", i, cntA, doneA, (i + 1) % 8, i == 7);
      end
    end
    total++;
    if (pdoA !== 8'hB2 || pdoB !== 8'hB2) begin
      bad++;
      $display("FAIL msb_word: got A=%h B=%h, expected b2", pdoA, pdoB);
    end
    tick();
    total++;
    if (doneA !== 1'b0) begin
      bad++;
      $display("FAIL msb_done_width: got %b, expected 0", doneA);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] outBits;
    int dones;
    outBits = 8'hC4;
    dones   = 0;
    frameActive = 1'b0; lsbFirst = 1'b1;
    tick();
    frameActive = 1'b1; parallelLoad = 1'b1; parallelDataIn = 8'hC4;
    tick();
    parallelLoad = 1'b0; shiftEdge = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (sdoA !== outBits[i]) begin
        bad++;
        $display("FAIL lsb_sdo[%0d]: got %b, expected %b", i, sdoA, outBits[i]);
      end
      serialDataIn = 1'($urandom_range(0, 1));
      tick();
      if (doneA) dones++;
    end
    shiftEdge = 1'b0;
    repeat (2) begin
      tick();
      if (doneA) dones++;
    end
    total++;
    if (dones != 1 || pdoA !== 8'(mShreg[0]) || pdoB !== 8'(mShreg[1])) begin
      bad++;
      $display("FAIL lsb_word: got dones=%0d A=%h B=%h, expected dones=1 A=%h B=%h", dones, pdoA, pdoB, 8'(mShreg[0]), 8'(mShreg[1]));
    end
    frameActive = 1'b0;
    tick();
    lsbFirst = 1'b0;
  endtask

  task automatic test_frame_drop();
    logic [7:0] held;
    frameActive = 1'b1; shiftEdge = 1'b1;
    repeat (5) tick();
    total++;
    if (cntA !== 3'd5) begin
      bad++;
      $display("FAIL drop_pre: got cnt=%0d, expected 5", cntA);
    end
    held = pdoA;
    frameActive = 1'b0; sampleEdge = 1'b1;
    repeat (3) tick();
    total++;
    if (cntA !== 3'd0 || doneA !== 1'b0 || pdoA !== held) begin
      bad++;
      $display("FAIL drop_idle: got cnt=%0d done=%b word=%h, expected cnt=0 done=0 word=%h", cntA, doneA, pdoA, held);
    end
    sampleEdge = 1'b0; frameActive = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (doneA !== (i == 8)) begin
        bad++;
        $display("FAIL drop_next[%0d]: got done=%b, expected %b", i, doneA, i == 8);
      end
    end
    quietInputs();
  endtask

  task automatic test_load_priority();
    frameActive = 1'b1; shiftEdge = 1'b1;
    repeat (7) tick();
    parallelLoad = 1'b1; parallelDataIn = 8'h5A;
    tick();
    total++;
    if (pdoA !== 8'h5A || pdoB !== 8'h5A || cntA !== 3'd0 || doneA !== 1'b0) begin
      bad++;
      $display("FAIL load_priority: got A=%h B=%h cnt=%0d done=%b, expected 5a 5a 0 0", pdoA, pdoB, cntA, doneA);
    end
    quietInputs();
  endtask

  task automatic test_sample_shift_same();
    frameActive = 1'b1; lsbFirst = 1'b0; parallelLoad = 1'b1; parallelDataIn = 8'h00;
    tick();
    parallelLoad = 1'b0; sampleEdge = 1'b1; serialDataIn = 1'b1;
    tick();
    serialDataIn = 1'b0; shiftEdge = 1'b1;
    tick();
    total++;
    if (pdoA !== 8'h01 || pdoB !== 8'h00) begin
      bad++;
      $display("FAIL same_edge: got A=%h B=%h, expected A=01 B=00", pdoA, pdoB);
    end
    sampleEdge = 1'b0; serialDataIn = 1'b1;
    tick();
    total++;
    if (pdoA !== 8'h02 || pdoB !== 8'h01) begin
      bad++;
      $display("FAIL same_edge_next: got A=%h B=%h, expected A=02 B=01", pdoA, pdoB);
    end
    quietInputs();
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    frameActive = 1'b1; parallelLoad = 1'b1; parallelDataIn = 8'($urandom);
    tick();
    parallelLoad = 1'b0; shiftEdge = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      sampleEdge   = 1'($urandom_range(0, 1));
      serialDataIn = 1'($urandom_range(0, 1));
      tick();
      if (doneA) dones++;
      total++;
      if (doneA !== (i % 8 == 0) || doneB !== doneA || pdoA !== 8'(mShreg[0]) || pdoB !== 8'(mShreg[1])) begin
        bad++;
        $display("FAIL b2b[%0d]: got done=%b/%b A=%h B=%h, expected done=%b A=%h B=%h", i, doneA, doneB, pdoA, pdoB, i % 8 == 0, 8'(mShreg[0]), 8'(mShreg[1]));
      end
    end
    total++;
    if (dones != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d pulses, expected 3", dones);
    end
    quietInputs();
  endtask

  task automatic test_random();
    int expSdo;
    for (int i = 0; i < 600; i++) begin
      frameActive    = ($urandom_range(0, 19) != 0);
      if (!frameActive) lsbFirst = 1'($urandom_range(0, 1));
      sampleEdge     = 1'($urandom_range(0, 1));
      shiftEdge      = 1'($urandom_range(0, 1));
      parallelLoad   = ($urandom_range(0, 15) == 0);
      parallelDataIn = 8'($urandom);
      serialDataIn   = 1'($urandom_range(0, 1));
      tick();
      expSdo = lsbFirst ? (mShreg[0] % 2) : (mShreg[0] / (1 << (W - 1)));
      total++;
      if (pdoA !== 8'(mShreg[0]) || pdoB !== 8'(mShreg[1]) || sdoA !== 1'(expSdo) ||
          cntA !== 3'(mCount) || cntB !== 3'(mCount) || doneA !== 1'(mDone) || doneB !== 1'(mDone)) begin
        bad++;
        $display("FAIL random[%0d]: got A=%h B=%h sdo=%b cnt=%0d done=%b, expected A=%h B=%h sdo=%0d cnt=%0d done=%0d",
                 i, pdoA, pdoB, sdoA, cntA, doneA, 8'(mShreg[0]), 8'(mShreg[1]), expSdo, mCount, mDone);
      end
    end
    quietInputs();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_frame_drop();
    test_load_priority();
    test_sample_shift_same();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
